// File: rtl/sw_pkg.sv
// sw_pkg: shared base encodings, default score width and feeder state enum
// for the Smith-Waterman systolic array blocks.
package sw_pkg;

    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_C = 2'b01;
    localparam logic [1:0] BASE_G = 2'b10;
    localparam logic [1:0] BASE_T = 2'b11;

    localparam int SW_SCORE_WIDTH = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } feeder_state_e;

endpackage

// File: rtl/sw_feeder_cnt.sv
// sw_feeder_cnt: loadable saturating up-counter with a terminal-count flag.
module sw_feeder_cnt #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = ld_i ? ld_val_i : (inc_i && cnt_q != MAX_V) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = cnt_q == MAX_V;

endmodule

// File: rtl/sw_array_feeder.sv
// sw_array_feeder: head-end sequencer loading the read and streaming reference columns into PE 0.
// Optional SW_FEEDER_REF_COUNT_EN adds ref_count and the REF_MAX_LEN overflow abort (err).
module sw_array_feeder
    import sw_pkg::*;
#(
    parameter int READ_LEN    = 6,
    parameter int SCORE_WIDTH = SW_SCORE_WIDTH,
    parameter int REF_MAX_LEN = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [1:0]                       read_base,
    input  logic                             read_valid,
    output logic                             read_ready,
    input  logic [1:0]                       ref_base,
    input  logic                             ref_last,
    input  logic                             ref_valid,
    output logic                             ref_ready,
    output logic [SCORE_WIDTH-1:0]           V_out,
    output logic [SCORE_WIDTH-1:0]           F_out,
    output logic [1:0]                       T_out,
    output logic [1:0]                       S_out,
    output logic                             store_S_out,
    output logic                             init_out,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic [$clog2(REF_MAX_LEN+1)-1:0] ref_count
);

    localparam int LCW = READ_LEN > 1 ? $clog2(READ_LEN) : 1;
    localparam int RCW = $clog2(REF_MAX_LEN + 1);

    feeder_state_e state_q, state_d;
    logic [1:0]    s_q, t_q;
    logic          store_q, init_q;
    logic          lc_ld, lc_inc, lc_tc;
    logic [LCW-1:0] lc_cnt;
    logic          rd_acc, rf_acc, ovf;

    // The same counter paces the READ_LEN loads and the READ_LEN drain cycles.
    sw_feeder_cnt #(.W(LCW), .MAX(READ_LEN - 1)) u_len_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld_i    (lc_ld),
        .ld_val_i('0),
        .inc_i   (lc_inc),
        .cnt_o   (lc_cnt),
        .tc_o    (lc_tc)
    );

`ifdef SW_FEEDER_REF_COUNT_EN
    logic err_q, rc_tc;
    logic job_start;
    assign job_start = state_q == ST_IDLE && start;
    sw_feeder_cnt #(.W(RCW), .MAX(REF_MAX_LEN)) u_ref_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld_i    (job_start),
        .ld_val_i('0),
        .inc_i   (rf_acc),
        .cnt_o   (ref_count),
        .tc_o    (rc_tc)
    );
    assign ref_ready = state_q == ST_STREAM && !rc_tc;
    assign ovf       = rf_acc && !ref_last && ref_count == RCW'(REF_MAX_LEN - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= job_start ? 1'b0 : err_q | ovf;
    end
    assign err = err_q;
`else
    assign ref_ready = state_q == ST_STREAM;
    assign ovf       = 1'b0;
    assign ref_count = '0;
    assign err       = 1'b0;
`endif

    assign read_ready = state_q == ST_LOAD;
    assign rd_acc     = read_ready && read_valid;
    assign rf_acc     = ref_ready && ref_valid;

    always_comb begin
        state_d = state_q;
        lc_ld   = 1'b0;
        lc_inc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = start ? ST_LOAD : ST_IDLE;
                lc_ld   = start;
            end
            ST_LOAD: begin
                state_d = (rd_acc && lc_tc) ? ST_STREAM : ST_LOAD;
                lc_ld   = rd_acc && lc_tc;
                lc_inc  = rd_acc && !lc_tc;
            end
            ST_STREAM: state_d = (rf_acc && (ref_last || ovf)) ? ST_DRAIN : ST_STREAM;
            ST_DRAIN: begin
                state_d = lc_tc ? ST_DONE : ST_DRAIN;
                lc_inc  = !lc_tc;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes track the accept edge; bases hold their value through bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            t_q     <= '0;
            store_q <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            store_q <= rd_acc;
            init_q  <= rf_acc;
            if (rd_acc) s_q <= read_base;
            if (rf_acc) t_q <= ref_base;
        end
    end

    assign V_out       = '0;
    assign F_out       = '0;
    assign S_out       = s_q;
    assign T_out       = t_q;
    assign store_S_out = store_q;
    assign init_out    = init_q;
    assign busy        = state_q != ST_IDLE;
    assign done        = state_q == ST_DONE;

endmodule
